// File: rtl/mem_stage_waitstate.sv
// MEM pipeline stage: 32-bit data array with byte/half/word access, sign/zero extension,
// a programmable number of wait states and an address-fault check.
module mem_stage_waitstate #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [1:0]        size_in,
    input  logic              sign_ext_in,
    input  logic [ADDR_W-1:0] alu_res_in,
    input  logic [31:0]       val_rm_in,
    output logic [31:0]       data_mem_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              ready_out,
    output logic              fault_out
);

    localparam int unsigned       IdxW    = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] BaseA   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] SpanA   = ADDR_W'(4 * DEPTH);
    localparam logic [3:0]        CntInit = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e state_q, state_d;

    logic [3:0]      cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [1:0]      lane_q, lane_d;
    logic [1:0]      size_q, size_d;
    logic            sign_q, sign_d;
    logic            wr_q, wr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0] mem_q [DEPTH];

    logic              req;
    logic              fault;
    logic              start;
    logic              commit;
    logic [ADDR_W-1:0] off;
    logic [31:0]       rword;
    logic [31:0]       rshift;
    logic [31:0]       load_val;
    logic [31:0]       wdata_al;
    logic [3:0]        be;

    assign req    = mem_read_in | mem_write_in;
    assign off    = alu_res_in - BaseA;
    assign pc_out = pc_in;

    always_comb begin
        fault = 1'b0;
        if (mem_read_in && mem_write_in)                 fault = 1'b1;
        if (size_in == 2'b11)                            fault = 1'b1;
        if (size_in == 2'b01 && off[0])                  fault = 1'b1;
        if (size_in == 2'b10 && off[1:0] != 2'b00)       fault = 1'b1;
        if (alu_res_in < BaseA)                          fault = 1'b1;
        if (off >= SpanA)                                fault = 1'b1;
    end

    assign start  = (state_q == StIdle) && req && !fault;
    assign commit = (state_q == StBusy) && (cnt_q == 4'd0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start)  state_d = StBusy;
            StBusy:  if (commit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        ready_out    = 1'b1;
        fault_out    = 1'b0;
        data_mem_out = 32'd0;
        unique case (state_q)
            StIdle: begin
                ready_out = !start;
                fault_out = req && fault;
            end
            StBusy:  ready_out = 1'b0;
            StDone:  data_mem_out = rdata_q;
            default: ready_out = 1'b1;
        endcase
    end

    // Load path: select the addressed lane, then extend
    always_comb begin
        rword  = mem_q[idx_q];
        rshift = rword >> {lane_q, 3'b000};
        unique case (size_q)
            2'b00:   load_val = sign_q ? {{24{rshift[7]}}, rshift[7:0]}
                                       : {24'd0, rshift[7:0]};
            2'b01:   load_val = sign_q ? {{16{rshift[15]}}, rshift[15:0]}
                                       : {16'd0, rshift[15:0]};
            default: load_val = rword;
        endcase
    end

    // Store path: align data to its lanes and build byte enables
    always_comb begin
        wdata_al = wdata_q << {lane_q, 3'b000};
        unique case (size_q)
            2'b00:   be = 4'b0001 << lane_q;
            2'b01:   be = 4'b0011 << {lane_q[1], 1'b0};
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        sign_d  = sign_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (start) begin
            cnt_d   = CntInit;
            idx_d   = off[IdxW+1:2];
            lane_d  = off[1:0];
            size_d  = size_in;
            sign_d  = sign_ext_in;
            wr_d    = mem_write_in;
            wdata_d = val_rm_in;
        end else if (state_q == StBusy) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                rdata_d = wr_q ? 32'd0 : load_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            lane_q  <= 2'd0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Array has no reset; an aborted access never reaches commit
    always_ff @(posedge clk) begin
        if (commit && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx_q][8*b +: 8] <= wdata_al[8*b +: 8];
            end
        end
    end

endmodule
